// File: rtl/ct_pkg.sv
// Shared definitions for the clock-crossing read path: crossing read latency,
// minimum read-adapter depth and the explicit-wrap pointer increment.
package ct_pkg;

  localparam int CT_RD_LATENCY        = 1;
  localparam int CT_ADAPTER_MIN_DEPTH = 3;

  // Pointers run 0..depth-1 and wrap explicitly, so depth need not be a power of two.
  function automatic int unsigned ct_wrap_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/ct_rd_outreg.sv
// One-entry valid/ready output register: refills whenever empty or being popped,
// adds one cycle of latency, holds data stable while dst_valid && !dst_ready.
module ct_rd_outreg #(
  parameter int WIDTH = 1
) (
  input  logic             rdclk,
  input  logic             rdarst,
  input  logic [WIDTH-1:0] src_data,
  input  logic             src_valid,
  output logic             src_ready,
  output logic [WIDTH-1:0] dst_data,
  output logic             dst_valid,
  input  logic             dst_ready
);

  assign src_ready = !dst_valid || dst_ready;

  always_ff @(posedge rdclk or posedge rdarst) begin
    if (rdarst) begin
      dst_valid <= 1'b0;
      dst_data  <= '0;
    end else if (src_ready) begin
      dst_valid <= src_valid;
      if (src_valid) dst_data <= src_data;
    end
  end

endmodule

// File: rtl/ct_rd_adapter.sv
// Credit-driven read stage behind the clock-crossing FIFO: c_req N -> c_valid N+1 -> o_valid N+2
// (one more cycle with CT_RD_ADAPTER_OUTREG_EN); c_req throttles so in-flight words always fit.
module ct_rd_adapter #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic                       rdclk,
  input  logic                       rdarst,
  input  logic [WIDTH-1:0]           c_data,
  input  logic                       c_valid,
  output logic                       c_req,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [$clog2(DEPTH+1)-1:0] o_level,
  output logic                       o_ovf
);
  import ct_pkg::*;

  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef CT_RD_ADAPTER_OUTREG_EN
  localparam int MIN_DEPTH = CT_ADAPTER_MIN_DEPTH + 1;
`else
  localparam int MIN_DEPTH = CT_ADAPTER_MIN_DEPTH;
`endif
  localparam logic [LW-1:0] FULL  = LW'(DEPTH);
  localparam logic [LW-1:0] ONE   = LW'(1);
  localparam logic [LW:0]   LIMIT = (LW + 1)'(DEPTH);

  if (DEPTH < MIN_DEPTH) begin : g_depth_chk
    $fatal(1, "ct_rd_adapter: DEPTH below the minimum for this build");
  end
  if (CT_RD_LATENCY != 1) begin : g_lat_chk
    $fatal(1, "ct_rd_adapter: credit rule only covers a one-cycle crossing read latency");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [LW-1:0]    occ;
  logic             c_req_q;
  logic             rst_q;
  logic             full;
  logic             push;
  logic             pop;
  logic             buf_pop;

  assign full = (occ == FULL);
  assign pop  = o_valid && i_ready;
  // A full buffer still takes a word when the head leaves in the same cycle.
  assign push = c_valid && (!full || pop);

  // Only registers feed the credit rule: occupancy plus the one request still in flight.
  assign c_req   = !rst_q && (({1'b0, occ} + {{LW{1'b0}}, c_req_q}) < LIMIT);
  assign o_level = occ;

`ifdef CT_RD_ADAPTER_OUTREG_EN
  logic head_vld;
  logic head_rdy;

  // occ counts the output register too, so the buffer holds occ minus that entry.
  assign head_vld = (occ > LW'(o_valid));
  assign buf_pop  = head_vld && head_rdy;

  ct_rd_outreg #(
    .WIDTH(WIDTH)
  ) u_outreg (
    .rdclk     (rdclk),
    .rdarst    (rdarst),
    .src_data  (mem[rd_ptr]),
    .src_valid (head_vld),
    .src_ready (head_rdy),
    .dst_data  (o_data),
    .dst_valid (o_valid),
    .dst_ready (i_ready)
  );
`else
  assign o_data  = mem[rd_ptr];
  assign o_valid = (occ != '0);
  assign buf_pop = pop;
`endif

  // Held for one rdclk after reset release so c_req comes up one cycle late.
  always_ff @(posedge rdclk or posedge rdarst) begin
    if (rdarst) rst_q <= 1'b1;
    else        rst_q <= 1'b0;
  end

  always_ff @(posedge rdclk or posedge rdarst) begin
    if (rdarst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      occ     <= '0;
      c_req_q <= 1'b0;
      o_ovf   <= 1'b0;
    end else begin
      c_req_q <= c_req;
      if (push)    wr_ptr <= PW'(ct_wrap_inc(32'(wr_ptr), DEPTH));
      if (buf_pop) rd_ptr <= PW'(ct_wrap_inc(32'(rd_ptr), DEPTH));
      if (push && !pop)      occ <= occ + ONE;
      else if (pop && !push) occ <= occ - ONE;
      // A dropped word leaves pointers and occupancy untouched.
      if (c_valid && !push) o_ovf <= 1'b1;
    end
  end

  always_ff @(posedge rdclk) begin
    if (push) mem[wr_ptr] <= c_data;
  end

endmodule

// File: tb/tb_ct_rd_adapter.sv
// Three adapters (DEPTH base, base+1, base+2) under identical directed stimulus,
// each with its own crossing model feeding an expected-word queue and a popping monitor.
module tb_ct_rd_adapter;

  localparam int NI = 3;
`ifdef CT_RD_ADAPTER_OUTREG_EN
  localparam int DBASE = 4;
  localparam int LAT   = 3;
`else
  localparam int DBASE = 3;
  localparam int LAT   = 2;
`endif

  logic rdclk  = 1'b0;
  logic rdarst = 1'b0;
  logic rdy    = 1'b0;
  logic avail  = 1'b1;
  logic inj    = 1'b0;
  logic exp_ovf = 1'b0;
  int   lim    = 0;
  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_fail = 0;

  int sent      [NI] = '{0, 0, 0};
  int first_req [NI] = '{-1, -1, -1};
  int first_vld [NI] = '{-1, -1, -1};
  int last_pop  [NI] = '{0, 0, 0};
  int npop      [NI] = '{0, 0, 0};
  int dep       [NI] = '{DBASE, DBASE + 1, DBASE + 2};
  logic [7:0] exp_q [NI][$];

  wire       req_a [NI];
  wire       vld_a [NI];
  wire       ovf_a [NI];
  wire [7:0] dat_a [NI];
  wire [7:0] lvl_a [NI];

  always #5 rdclk = ~rdclk;
  always @(posedge rdclk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int inst, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s inst%0d: got 0x%0h, required 0x%0h", nm, inst, act, exp);
    end
  endtask

  function automatic bit all_done();
    for (int i = 0; i < NI; i++)
      if (sent[i] != lim || exp_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int DEP = DBASE + gi;
    logic [7:0] cd;
    logic       cv;
    logic       pend;
    logic [7:0] pw;
    logic [7:0] e;
    int         nxt;
    wire        cr;
    wire  [7:0] od;
    wire        ov;
    wire        of;
    wire  [$clog2(DEP+1)-1:0] lv;

    ct_rd_adapter #(.WIDTH(8), .DEPTH(DEP)) u_dut (
      .rdclk   (rdclk),
      .rdarst  (rdarst),
      .c_data  (cd),
      .c_valid (cv),
      .c_req   (cr),
      .o_data  (od),
      .o_valid (ov),
      .i_ready (rdy),
      .o_level (lv),
      .o_ovf   (of)
    );

    assign req_a[gi] = cr;
    assign vld_a[gi] = ov;
    assign ovf_a[gi] = of;
    assign dat_a[gi] = od;
    assign lvl_a[gi] = 8'(lv);

    // Crossing model: a request seen in cycle N returns a word in cycle N+1 if non-empty.
    initial begin
      cv = 1'b0; cd = 8'h00; nxt = 1; pend = 1'b0; pw = 8'h00;
      forever begin
        @(negedge rdclk);
        pend = 1'b0;
        if (rdarst) begin
          exp_q[gi].delete();
        end else if (inj) begin
          pend = 1'b1;
          pw   = 8'hAA;
        end else if (cr && avail && sent[gi] < lim) begin
          if (nxt[7:0] == 8'hAA) nxt++;
          if (nxt[7:0] == 8'h00) nxt++;
          pw = nxt[7:0];
          nxt++;
          sent[gi]++;
          pend = 1'b1;
          exp_q[gi].push_back(pw);
        end
        @(posedge rdclk);
        #1;
        cv = pend;
        cd = pend ? pw : 8'h00;
      end
    end

    always @(negedge rdclk) begin
      chk("level_bound", gi, int'(int'(lv) <= DEP), 1);
      chk("ovf", gi, int'(of), int'(exp_ovf));
      if (cr && first_req[gi] < 0) first_req[gi] = cyc;
      if (ov && rdy) begin
        if (first_vld[gi] < 0) first_vld[gi] = cyc;
        last_pop[gi] = cyc;
        npop[gi]++;
        if (exp_q[gi].size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_word inst%0d: got 0x%02h, required no word", gi, od);
        end else begin
          e = exp_q[gi].pop_front();
          chk("data", gi, int'(od), int'(e));
        end
      end
    end
  end

  task automatic drain(input string nm);
    int t;
    t = 0;
    rdy = 1'b1;
    avail = 1'b1;
    while (!all_done() && t < 3000) begin
      @(posedge rdclk);
      #1;
      t++;
    end
    chk({nm, "_drained"}, 0, int'(all_done()), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    int pct [3] = '{30, 70, 100};
    int t;
    #1 rdarst = 1'b1;

    // Reset state
    repeat (3) @(posedge rdclk);
    @(negedge rdclk);
    for (int i = 0; i < NI; i++) begin
      chk("rst_o_valid", i, int'(vld_a[i]), 0);
      chk("rst_c_req", i, int'(req_a[i]), 0);
      chk("rst_o_level", i, int'(lvl_a[i]), 0);
      chk("rst_o_ovf", i, int'(ovf_a[i]), 0);
    end
    lim = 64;
    rdy = 1'b1;
    @(posedge rdclk);
    #1 rdarst = 1'b0;
    @(negedge rdclk);
    for (int i = 0; i < NI; i++) chk("rel_c_req_cycle0", i, int'(req_a[i]), 0);
    @(negedge rdclk);
    for (int i = 0; i < NI; i++) chk("rel_c_req_cycle1", i, int'(req_a[i]), 1);

    // Streaming 0x01..0x40
    drain("stream");
    for (int i = 0; i < NI; i++) begin
      chk("stream_latency", i, first_vld[i] - first_req[i], LAT);
      chk("stream_span", i, last_pop[i] - first_vld[i], 63);
      chk("stream_count", i, npop[i], 64);
    end

    // Stall mid-stream for 20 cycles
    lim += 40;
    repeat (10) @(posedge rdclk);
    #1 rdy = 1'b0;
    repeat (3) @(posedge rdclk);
    @(negedge rdclk);
    for (int i = 0; i < NI; i++)
      chk("stall_head", i, int'(dat_a[i]), exp_q[i].size() > 0 ? int'(exp_q[i][0]) : -1);
    repeat (17) @(negedge rdclk);
    for (int i = 0; i < NI; i++) begin
      chk("stall_level", i, int'(lvl_a[i]), dep[i]);
      chk("stall_c_req", i, int'(req_a[i]), 0);
      chk("stall_held", i, int'(dat_a[i]), exp_q[i].size() > 0 ? int'(exp_q[i][0]) : -1);
    end
    @(posedge rdclk);
    #1;
    drain("stall");

    // Random bubbles on both sides
    for (int p = 0; p < 3; p++) begin
      lim += 60;
      t = 0;
      while (!all_done() && t < 3000) begin
        @(posedge rdclk);
        #1;
        rdy   = ($urandom_range(0, 99) < pct[p]);
        avail = ($urandom_range(0, 2) != 0);
        t++;
      end
      drain("random");
    end

    // Forced overflow with a full buffer and no consumer
    lim += 8;
    rdy = 1'b0;
    repeat (12) @(posedge rdclk);
    @(negedge rdclk);
    for (int i = 0; i < NI; i++) begin
      chk("pre_ovf_level", i, int'(lvl_a[i]), dep[i]);
      chk("pre_ovf_c_req", i, int'(req_a[i]), 0);
    end
    @(posedge rdclk);
    #2 inj = 1'b1;
    @(posedge rdclk);
    #2 inj = 1'b0;
    @(posedge rdclk);
    #1 exp_ovf = 1'b1;
    repeat (5) @(negedge rdclk);
    for (int i = 0; i < NI; i++) begin
      chk("ovf_set", i, int'(ovf_a[i]), 1);
      chk("ovf_level", i, int'(lvl_a[i]), dep[i]);
    end
    @(posedge rdclk);
    #1;
    drain("ovf");
    for (int i = 0; i < NI; i++) chk("ovf_sticky", i, int'(ovf_a[i]), 1);

    // Reset with two words buffered
    lim += 2;
    rdy = 1'b0;
    repeat (8) @(posedge rdclk);
    @(negedge rdclk);
    for (int i = 0; i < NI; i++) begin
      chk("pre_rst_level", i, int'(lvl_a[i]), 2);
      chk("pre_rst_valid", i, int'(vld_a[i]), 1);
    end
    @(posedge rdclk);
    #3;
    exp_ovf = 1'b0;
    rdarst  = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) chk("async_rst_valid", i, int'(vld_a[i]), 0);
    repeat (3) @(posedge rdclk);
    #1 rdarst = 1'b0;
    lim += 6;
    drain("post_rst");
    for (int i = 0; i < NI; i++) chk("post_rst_ovf", i, int'(ovf_a[i]), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
